// File: rtl/time_sync_pkg.sv
// ----------------------------------------------------------------------------
// time_sync_pkg
//   Shared constants for the sync receive path: ToD field layout, nanoseconds
//   per second, default sync identifier width and lock FSM state encodings.
//   ToD format (96 bits): {sec[47:0], ns[31:0], fns[15:0]}.
// ----------------------------------------------------------------------------
package time_sync_pkg;

   localparam int TOD_WIDTH = 96;

   localparam int FNS_LSB = 0;
   localparam int FNS_MSB = 15;
   localparam int NS_LSB  = 16;
   localparam int NS_MSB  = 47;
   localparam int SEC_LSB = 48;
   localparam int SEC_MSB = 95;

   localparam int IDENTIFIER_WIDTH = 16;

   localparam logic signed [63:0] NS_PER_SEC = 64'sd1_000_000_000;

   // Lock FSM encodings, kept as plain constants so existing CSR decode that
   // reads the raw state value stays compatible.
   localparam logic [1:0] LOCK_UNLOCKED  = 2'd0;
   localparam logic [1:0] LOCK_ACQUIRING = 2'd1;
   localparam logic [1:0] LOCK_LOCKED    = 2'd2;

endpackage

// File: rtl/time_sync_offset_calc.sv
// ----------------------------------------------------------------------------
// time_sync_offset_calc
//   Three-stage offset pipeline: S1 field differences, S2 64-bit signed offset
//   minus the fixed link delay, S3 saturation to OFFSET_WIDTH. Also classifies
//   the sample being loaded into S3 so the lock FSM can update on that edge.
// Ports
//   clk, rst          clock, async active-high reset (flushes every stage)
//   i_valid           accepted message entering S1
//   i_port            receiving interface of the message
//   i_tx_sec/i_tx_ns  master TX time (seconds / nanoseconds)
//   i_rx_sec/i_rx_ns  local RX time (seconds / nanoseconds)
//   o_valid           one-cycle pulse, new sample on the outputs
//   o_offset_ns       signed saturated offset (held between pulses)
//   o_port            port of the sample (held)
//   o_range_err       sample out of range or saturated (held)
//   o_result          S3 loads a sample on the coming edge
//   o_good            that sample is in range and within the threshold
// ----------------------------------------------------------------------------
module time_sync_offset_calc
   import time_sync_pkg::*;
#(
   parameter int PORT_ID_WIDTH    = 4,
   parameter int LINK_DELAY_NS    = 0,
   parameter int OFFSET_WIDTH     = 32,
   parameter int OFFSET_THRESH_NS = 100
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_valid,
   input  logic [PORT_ID_WIDTH-1:0]       i_port,
   input  logic [47:0]                    i_tx_sec,
   input  logic [31:0]                    i_tx_ns,
   input  logic [47:0]                    i_rx_sec,
   input  logic [31:0]                    i_rx_ns,
   output logic                           o_valid,
   output logic signed [OFFSET_WIDTH-1:0] o_offset_ns,
   output logic [PORT_ID_WIDTH-1:0]       o_port,
   output logic                           o_range_err,
   output logic                           o_result,
   output logic                           o_good
);

   localparam logic signed [63:0] LINK_DELAY_S = 64'(LINK_DELAY_NS);
   localparam logic signed [63:0] SAT_MAX      = (64'sd1 <<< (OFFSET_WIDTH - 1)) - 64'sd1;
   localparam logic signed [63:0] SAT_MIN      = -(64'sd1 <<< (OFFSET_WIDTH - 1));
   localparam logic signed [OFFSET_WIDTH-1:0] MAX_OW   = {1'b0, {(OFFSET_WIDTH-1){1'b1}}};
   localparam logic signed [OFFSET_WIDTH-1:0] MIN_OW   = {1'b1, {(OFFSET_WIDTH-1){1'b0}}};
   localparam logic signed [OFFSET_WIDTH-1:0] THRESH_S = OFFSET_WIDTH'(OFFSET_THRESH_NS);

   // ---------------- S1: field differences ----------------
   logic signed [48:0]       w_sec_d;
   logic signed [32:0]       w_ns_d;
   logic                     r_s1_valid;
   logic [PORT_ID_WIDTH-1:0] r_s1_port;
   logic signed [48:0]       r_s1_sec_d;
   logic signed [32:0]       r_s1_ns_d;

   // Zero-extend before subtracting so the borrow lands in the sign bit.
   assign w_sec_d = $signed({1'b0, i_rx_sec}) - $signed({1'b0, i_tx_sec});
   assign w_ns_d  = $signed({1'b0, i_rx_ns})  - $signed({1'b0, i_tx_ns});

   // NOTE: sequential state uses non-blocking assignments so every stage
   // samples the previous stage's pre-edge value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_port  <= '0;
         r_s1_sec_d <= '0;
         r_s1_ns_d  <= '0;
      end else begin
         r_s1_valid <= i_valid;
         if (i_valid) begin
            r_s1_port  <= i_port;
            r_s1_sec_d <= w_sec_d;
            r_s1_ns_d  <= w_ns_d;
         end
      end
   end

   // ---------------- S2: 64-bit offset ----------------
   // Only sec_d in {-1,0,+1} yields a usable offset, so the seconds term is a
   // three-way select rather than a multiplier.
   logic                     w_sec_ok;
   logic signed [63:0]       w_sec_term;
   logic signed [63:0]       w_off64;
   logic                     r_s2_valid;
   logic [PORT_ID_WIDTH-1:0] r_s2_port;
   logic signed [63:0]       r_s2_off;
   logic                     r_s2_sec_ok;
   logic                     r_s2_sec_neg;

   assign w_sec_ok   = (r_s1_sec_d == 49'sd0) || (r_s1_sec_d == 49'sd1) || (r_s1_sec_d == -49'sd1);
   assign w_sec_term = (r_s1_sec_d == 49'sd1)  ? NS_PER_SEC  :
                       (r_s1_sec_d == -49'sd1) ? -NS_PER_SEC : 64'sd0;
   assign w_off64    = $signed({{31{r_s1_ns_d[32]}}, r_s1_ns_d}) + w_sec_term - LINK_DELAY_S;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid   <= 1'b0;
         r_s2_port    <= '0;
         r_s2_off     <= '0;
         r_s2_sec_ok  <= 1'b0;
         r_s2_sec_neg <= 1'b0;
      end else begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_port    <= r_s1_port;
            r_s2_off     <= w_off64;
            r_s2_sec_ok  <= w_sec_ok;
            r_s2_sec_neg <= r_s1_sec_d[48];
         end
      end
   end

   // ---------------- S3: saturation ----------------
   logic                           w_sat_err;
   logic signed [OFFSET_WIDTH-1:0] w_sat_off;

   // NOTE: every always_comb output gets a default first so no path can
   // infer a latch.
   always_comb begin
      w_sat_err = 1'b0;
      w_sat_off = r_s2_off[OFFSET_WIDTH-1:0];
      if (!r_s2_sec_ok) begin
         w_sat_err = 1'b1;
         w_sat_off = r_s2_sec_neg ? MIN_OW : MAX_OW;
      end else if (r_s2_off > SAT_MAX) begin
         w_sat_err = 1'b1;
         w_sat_off = MAX_OW;
      end else if (r_s2_off < SAT_MIN) begin
         w_sat_err = 1'b1;
         w_sat_off = MIN_OW;
      end
   end

   assign o_result = r_s2_valid;
   assign o_good   = r_s2_valid & ~w_sat_err &
                     (w_sat_off <= THRESH_S) & (w_sat_off >= -THRESH_S);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid     <= 1'b0;
         o_offset_ns <= '0;
         o_port      <= '0;
         o_range_err <= 1'b0;
      end else begin
         o_valid <= r_s2_valid;
         if (r_s2_valid) begin
            o_offset_ns <= w_sat_off;
            o_port      <= r_s2_port;
            o_range_err <= w_sat_err;
         end
      end
   end

endmodule

// File: rtl/time_sync_receiver.sv
// ----------------------------------------------------------------------------
// time_sync_receiver
//   Receive-side sync message consumer. Filters by source ID, captures the
//   accepted message, computes the clock offset (time_sync_offset_calc), and
//   tracks lock state with a no-result watchdog.
// Ports
//   clk, rst          clock, async active-high reset
//   s_sync_*          decoded sync message stream (never backpressured)
//   offset_valid      one-cycle pulse, new offset sample
//   offset_ns         signed rx - tx - LINK_DELAY_NS, saturated
//   offset_port       port of the sample
//   offset_range_err  qualifies offset_valid: out of range or saturated
//   sync_locked       lock FSM is LOCKED
//   sync_rx_count     accepted syncs, saturating
//   sync_drop_count   ID-mismatched syncs, saturating
// ----------------------------------------------------------------------------
module time_sync_receiver
   import time_sync_pkg::*;
#(
   parameter int                          PORT_ID_WIDTH    = 4,
   parameter int                          IDENTIFIER_WIDTH = time_sync_pkg::IDENTIFIER_WIDTH,
   parameter logic [IDENTIFIER_WIDTH-1:0] EXPECTED_SRC_ID  = 16'h1176,
   parameter int                          LINK_DELAY_NS    = 0,
   parameter int                          OFFSET_WIDTH     = 32,
   parameter int                          OFFSET_THRESH_NS = 100,
   parameter int                          LOCK_COUNT       = 4,
   parameter int                          TIMEOUT_CYCLES   = 750000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           s_sync_valid,
   output logic                           s_sync_ready,
   input  logic [IDENTIFIER_WIDTH-1:0]    s_sync_src_id,
   input  logic [PORT_ID_WIDTH-1:0]       s_sync_port,
   input  logic [TOD_WIDTH-1:0]           s_sync_tx_tod,
   input  logic [TOD_WIDTH-1:0]           s_sync_rx_tod,
   output logic                           offset_valid,
   output logic signed [OFFSET_WIDTH-1:0] offset_ns,
   output logic [PORT_ID_WIDTH-1:0]       offset_port,
   output logic                           offset_range_err,
   output logic                           sync_locked,
   output logic [31:0]                    sync_rx_count,
   output logic [31:0]                    sync_drop_count
);

   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W = $clog2(LOCK_COUNT + 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_TERM  = WD_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LOCK_CNT = CNT_W'(LOCK_COUNT);

   // ---------------- handshake and filter ----------------
   logic w_xfer;
   logic w_accept;
   logic w_drop;
   logic w_unused_fns;

   assign s_sync_ready = ~rst;
   assign w_xfer       = s_sync_valid & s_sync_ready;
   assign w_accept     = w_xfer & (s_sync_src_id == EXPECTED_SRC_ID);
   assign w_drop       = w_xfer & (s_sync_src_id != EXPECTED_SRC_ID);
   // Fractional nanoseconds do not contribute to the offset.
   assign w_unused_fns = ^{s_sync_tx_tod[FNS_MSB:FNS_LSB], s_sync_rx_tod[FNS_MSB:FNS_LSB]};

   // Capture stage: registers the accepted message on the transfer edge.
   logic                     r_cap_valid;
   logic [PORT_ID_WIDTH-1:0] r_cap_port;
   logic [47:0]              r_cap_tx_sec;
   logic [31:0]              r_cap_tx_ns;
   logic [47:0]              r_cap_rx_sec;
   logic [31:0]              r_cap_rx_ns;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cap_valid  <= 1'b0;
         r_cap_port   <= '0;
         r_cap_tx_sec <= '0;
         r_cap_tx_ns  <= '0;
         r_cap_rx_sec <= '0;
         r_cap_rx_ns  <= '0;
      end else begin
         r_cap_valid <= w_accept;
         if (w_accept) begin
            r_cap_port   <= s_sync_port;
            r_cap_tx_sec <= s_sync_tx_tod[SEC_MSB:SEC_LSB];
            r_cap_tx_ns  <= s_sync_tx_tod[NS_MSB:NS_LSB];
            r_cap_rx_sec <= s_sync_rx_tod[SEC_MSB:SEC_LSB];
            r_cap_rx_ns  <= s_sync_rx_tod[NS_MSB:NS_LSB];
         end
      end
   end

   // ---------------- counters ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_rx_count   <= '0;
         sync_drop_count <= '0;
      end else begin
         if (w_accept && (sync_rx_count != 32'hFFFF_FFFF))
            sync_rx_count <= sync_rx_count + 32'd1;
         if (w_drop && (sync_drop_count != 32'hFFFF_FFFF))
            sync_drop_count <= sync_drop_count + 32'd1;
      end
   end

   // ---------------- offset pipeline ----------------
   logic w_result;
   logic w_good;

   time_sync_offset_calc #(
      .PORT_ID_WIDTH    (PORT_ID_WIDTH),
      .LINK_DELAY_NS    (LINK_DELAY_NS),
      .OFFSET_WIDTH     (OFFSET_WIDTH),
      .OFFSET_THRESH_NS (OFFSET_THRESH_NS)
   ) u_offset_calc (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (r_cap_valid),
      .i_port      (r_cap_port),
      .i_tx_sec    (r_cap_tx_sec),
      .i_tx_ns     (r_cap_tx_ns),
      .i_rx_sec    (r_cap_rx_sec),
      .i_rx_ns     (r_cap_rx_ns),
      .o_valid     (offset_valid),
      .o_offset_ns (offset_ns),
      .o_port      (offset_port),
      .o_range_err (offset_range_err),
      .o_result    (w_result),
      .o_good      (w_good)
   );

   // ---------------- watchdog ----------------
   // Expiry is the edge on which the count reaches TIMEOUT_CYCLES; the count
   // then holds at terminal, which keeps forcing UNLOCKED harmlessly.
   logic [WD_W-1:0] r_wd_cnt;
   logic            w_wd_expire;

   assign w_wd_expire = (r_wd_cnt >= WD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_wd_cnt <= '0;
      else if (w_result)
         r_wd_cnt <= '0;
      else if (r_wd_cnt != WD_TERM)
         r_wd_cnt <= r_wd_cnt + 1'b1;
   end

   // ---------------- lock FSM ----------------
   // Updates on the same edge that loads S3, so sync_locked changes together
   // with the offset_valid pulse. A result always takes priority over expiry.
   logic [1:0]       r_lock_state;
   logic [CNT_W-1:0] r_lock_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock_state <= LOCK_UNLOCKED;
         r_lock_cnt   <= '0;
      end else if (w_result) begin
         case (r_lock_state)
            LOCK_UNLOCKED: begin
               if (w_good) begin
                  r_lock_cnt   <= CNT_W'(1);
                  r_lock_state <= (LOCK_COUNT == 1) ? LOCK_LOCKED : LOCK_ACQUIRING;
               end
            end
            LOCK_ACQUIRING: begin
               if (w_good) begin
                  r_lock_cnt <= r_lock_cnt + 1'b1;
                  if (r_lock_cnt + 1'b1 == LOCK_CNT)
                     r_lock_state <= LOCK_LOCKED;
               end else begin
                  r_lock_cnt   <= '0;
                  r_lock_state <= LOCK_UNLOCKED;
               end
            end
            LOCK_LOCKED: begin
               if (!w_good) begin
                  r_lock_cnt   <= '0;
                  r_lock_state <= LOCK_UNLOCKED;
               end
            end
            default: begin
               r_lock_cnt   <= '0;
               r_lock_state <= LOCK_UNLOCKED;
            end
         endcase
      end else if (w_wd_expire) begin
         r_lock_cnt   <= '0;
         r_lock_state <= LOCK_UNLOCKED;
      end
   end

   assign sync_locked = (r_lock_state == LOCK_LOCKED);

endmodule

// File: tb/tb_time_sync_receiver.sv
// ----------------------------------------------------------------------------
// tb_time_sync_receiver
//   Directed bench for time_sync_receiver. LINK_DELAY_NS=5 so every offset is
//   rx - tx - 5; TIMEOUT_CYCLES is shortened to keep the watchdog test brief.
// ----------------------------------------------------------------------------
module tb_time_sync_receiver;

   localparam int PW  = 4;
   localparam int IW  = 16;
   localparam int OW  = 32;
   localparam int TMO = 200;
   localparam logic [IW-1:0] GOOD_ID = 16'h1176;

   logic               clk = 1'b0;
   logic               rst;
   logic               s_sync_valid;
   logic               s_sync_ready;
   logic [IW-1:0]      s_sync_src_id;
   logic [PW-1:0]      s_sync_port;
   logic [95:0]        s_sync_tx_tod;
   logic [95:0]        s_sync_rx_tod;
   logic               offset_valid;
   logic signed [OW-1:0] offset_ns;
   logic [PW-1:0]      offset_port;
   logic               offset_range_err;
   logic               sync_locked;
   logic [31:0]        sync_rx_count;
   logic [31:0]        sync_drop_count;

   int checks = 0;
   int errors = 0;
   int exp_rx = 0;
   logic seen;

   time_sync_receiver #(
      .PORT_ID_WIDTH    (PW),
      .IDENTIFIER_WIDTH (IW),
      .EXPECTED_SRC_ID  (GOOD_ID),
      .LINK_DELAY_NS    (5),
      .OFFSET_WIDTH     (OW),
      .OFFSET_THRESH_NS (100),
      .LOCK_COUNT       (4),
      .TIMEOUT_CYCLES   (TMO)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .s_sync_valid     (s_sync_valid),
      .s_sync_ready     (s_sync_ready),
      .s_sync_src_id    (s_sync_src_id),
      .s_sync_port      (s_sync_port),
      .s_sync_tx_tod    (s_sync_tx_tod),
      .s_sync_rx_tod    (s_sync_rx_tod),
      .offset_valid     (offset_valid),
      .offset_ns        (offset_ns),
      .offset_port      (offset_port),
      .offset_range_err (offset_range_err),
      .sync_locked      (sync_locked),
      .sync_rx_count    (sync_rx_count),
      .sync_drop_count  (sync_drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [IW-1:0] id, input logic [PW-1:0] port,
                        input logic [47:0] txs, input logic [31:0] txn,
                        input logic [47:0] rxs, input logic [31:0] rxn);
      s_sync_valid  = 1'b1;
      s_sync_src_id = id;
      s_sync_port   = port;
      s_sync_tx_tod = {txs, txn, 16'hABCD};
      s_sync_rx_tod = {rxs, rxn, 16'h1234};
   endtask

   task automatic idle();
      s_sync_valid = 1'b0;
   endtask

   // One accepted sync; pulse expected after the third edge following transfer.
   task automatic send_check(input string tag,
                             input logic [47:0] txs, input logic [31:0] txn,
                             input logic [47:0] rxs, input logic [31:0] rxn,
                             input logic [31:0] exp_off, input logic exp_err,
                             input logic exp_lock);
      drive(GOOD_ID, 4'h3, txs, txn, rxs, rxn);
      step();
      idle();
      exp_rx++;
      step();
      step();
      check({tag, "_early"}, 32'(offset_valid), 32'd0);
      step();
      check({tag, "_valid"}, 32'(offset_valid), 32'd1);
      check({tag, "_offset"}, offset_ns, exp_off);
      check({tag, "_err"}, 32'(offset_range_err), 32'(exp_err));
      check({tag, "_locked"}, 32'(sync_locked), 32'(exp_lock));
   endtask

   // Four back-to-back syncs at offset +20; lock expected on the fourth pulse.
   task automatic lock_up(input string tag);
      for (int i = 0; i < 7; i++) begin
         if (i < 4) drive(GOOD_ID, 4'h5, 48'd5, 32'd100, 48'd5, 32'd125);
         else       idle();
         step();
         if (i < 4) exp_rx++;
         if (i >= 3) begin
            check({tag, "_pulse"}, 32'(offset_valid), 32'd1);
            check({tag, "_locked"}, 32'(sync_locked), 32'(i == 6));
         end
      end
      check({tag, "_offset"}, offset_ns, 32'd20);
      check({tag, "_port"}, 32'(offset_port), 32'h5);
   endtask

   initial begin
      rst           = 1'b1;
      s_sync_valid  = 1'b0;
      s_sync_src_id = '0;
      s_sync_port   = '0;
      s_sync_tx_tod = '0;
      s_sync_rx_tod = '0;

      // Reset state
      step();
      step();
      check("rst_ready", 32'(s_sync_ready), 32'd0);
      check("rst_valid", 32'(offset_valid), 32'd0);
      check("rst_offset", offset_ns, 32'd0);
      check("rst_locked", 32'(sync_locked), 32'd0);
      check("rst_rx_count", sync_rx_count, 32'd0);
      check("rst_drop_count", sync_drop_count, 32'd0);
      rst = 1'b0;
      #1;
      check("ready_after_rst", 32'(s_sync_ready), 32'd1);
      step();

      // 1: same second, +50 ns, minus 5 ns delay
      send_check("t1", 48'd5, 32'd100, 48'd5, 32'd150, 32'd45, 1'b0, 1'b0);
      check("t1_port", 32'(offset_port), 32'h3);
      check("t1_rx_count", sync_rx_count, 32'd1);
      step();
      check("t1_pulse_end", 32'(offset_valid), 32'd0);
      check("t1_hold", offset_ns, 32'd45);

      // 2: second rollover in both directions
      send_check("t2a", 48'd5, 32'd999_999_990, 48'd6, 32'd10, 32'd15, 1'b0, 1'b0);
      send_check("t2b", 48'd6, 32'd10, 48'd5, 32'd999_999_990, -32'sd25, 1'b0, 1'b0);

      // 3: second differences outside {-1,0,+1}, and 32-bit saturation
      send_check("t3_sec_p2", 48'd5, 32'd0, 48'd7, 32'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
      send_check("t3_sec_m2", 48'd7, 32'd0, 48'd5, 32'd0, 32'h8000_0000, 1'b1, 1'b0);
      send_check("t3_ns_sat", 48'd5, 32'd0, 48'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);

      // 4: lock after four good samples (count restarted by the bad ones above),
      //    then one sample at +200 drops lock
      lock_up("t4");
      send_check("t4_bad", 48'd5, 32'd100, 48'd5, 32'd305, 32'd200, 1'b0, 1'b0);
      check("t4_rx_count", sync_rx_count, 32'(exp_rx));

      // 5a: watchdog expiry exactly TMO edges after the last result
      lock_up("t5a");
      for (int k = 1; k < TMO; k++) step();
      check("t5a_before_expiry", 32'(sync_locked), 32'd1);
      step();
      check("t5a_at_expiry", 32'(sync_locked), 32'd0);

      // 5b: a result landing on the expiry edge keeps lock
      lock_up("t5b");
      for (int k = 0; k < TMO - 4; k++) step();
      drive(GOOD_ID, 4'h5, 48'd5, 32'd100, 48'd5, 32'd125);
      step();
      idle();
      exp_rx++;
      step();
      step();
      step();
      check("t5b_result_pulse", 32'(offset_valid), 32'd1);
      check("t5b_locked_at_expiry", 32'(sync_locked), 32'd1);
      step();
      check("t5b_locked_after", 32'(sync_locked), 32'd1);

      // 6a: mismatched source IDs are counted and dropped
      for (int k = 0; k < 3; k++) begin
         drive(16'h0001, 4'h2, 48'd5, 32'd100, 48'd5, 32'd125);
         step();
      end
      idle();
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         seen |= offset_valid;
      end
      check("t6_drop_count", sync_drop_count, 32'd3);
      check("t6_rx_unchanged", sync_rx_count, 32'(exp_rx));
      check("t6_no_pulse", 32'(seen), 32'd0);

      // 6b: reset with two accepted syncs in flight flushes the pipeline
      for (int k = 0; k < 2; k++) begin
         drive(GOOD_ID, 4'h1, 48'd5, 32'd100, 48'd5, 32'd125);
         step();
      end
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         seen |= offset_valid;
      end
      check("t6_flush_no_pulse", 32'(seen), 32'd0);
      check("t6_flush_locked", 32'(sync_locked), 32'd0);
      check("t6_flush_rx_count", sync_rx_count, 32'd0);
      check("t6_flush_drop_count", sync_drop_count, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
